// File: rtl/fwd_hazard_ctrl.sv
// ============================================================================
//  Module   : fwd_hazard_ctrl
//  Purpose  : EX-stage forwarding selects, load-use stall and ID/EX bubble
//             control for a 5-stage RV32I pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_ctrl #(
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_rs1_used,
    input  logic          id_rs2_used,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          ex_flush,
    output logic [1:0]    fwd_a_sel,
    output logic [1:0]    fwd_b_sel,
    output logic          stall,
    output logic          idex_bubble
);

    localparam logic [RW-1:0] c_X0 = '0;

    // ID/EX record
    logic          idex_v_q,  idex_v_d;
    logic [RW-1:0] idex_rs1_q, idex_rs1_d;
    logic [RW-1:0] idex_rs2_q, idex_rs2_d;
    logic          idex_rs1_used_q, idex_rs1_used_d;
    logic          idex_rs2_used_q, idex_rs2_used_d;
    logic [RW-1:0] idex_rd_q, idex_rd_d;
    logic          idex_rw_q, idex_rw_d;
    logic          idex_mr_q, idex_mr_d;
    // EX/MEM record
    logic          exm_v_q,  exm_v_d;
    logic [RW-1:0] exm_rd_q, exm_rd_d;
    logic          exm_rw_q, exm_rw_d;
    logic          exm_mr_q, exm_mr_d;
    // MEM/WB record
    logic          mwb_v_q,  mwb_v_d;
    logic [RW-1:0] mwb_rd_q, mwb_rd_d;
    logic          mwb_rw_q, mwb_rw_d;

    logic          w_hz;
    logic          w_exm_prod;
    logic          w_mwb_prod;
    logic [RW-1:0] w_src    [2];
    logic          w_used   [2];
    logic [1:0]    w_sel    [2];

    // Load-use: the load in EX has no data until MEM completes, so the consumer in ID waits a cycle.
    assign w_hz = id_valid & idex_v_q & idex_mr_q & (idex_rd_q != c_X0)
                & ((id_rs1_used & (id_rs1 == idex_rd_q))
                 | (id_rs2_used & (id_rs2 == idex_rd_q)));

    assign stall       = w_hz & ~ex_flush;
    assign idex_bubble = stall | ex_flush;

    assign w_exm_prod = exm_v_q & exm_rw_q & (exm_rd_q != c_X0);
    assign w_mwb_prod = mwb_v_q & mwb_rw_q & (mwb_rd_q != c_X0);

    assign w_src[0]  = idex_rs1_q;
    assign w_src[1]  = idex_rs2_q;
    assign w_used[0] = idex_rs1_used_q;
    assign w_used[1] = idex_rs2_used_q;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_operand
            logic w_exm_hit;
            logic w_mwb_hit;
            assign w_exm_hit = idex_v_q & w_used[g] & w_exm_prod & (exm_rd_q == w_src[g]);
            assign w_mwb_hit = idex_v_q & w_used[g] & w_mwb_prod & (mwb_rd_q == w_src[g]);
            assign w_sel[g]  = w_exm_hit ? 2'b01 : (w_mwb_hit ? 2'b10 : 2'b00);
        end
    endgenerate

    assign fwd_a_sel = w_sel[0];
    assign fwd_b_sel = w_sel[1];

    always_comb begin
        idex_v_d        = id_valid & ~idex_bubble;
        idex_rs1_d      = id_rs1;
        idex_rs2_d      = id_rs2;
        idex_rs1_used_d = id_rs1_used;
        idex_rs2_used_d = id_rs2_used;
        idex_rd_d       = id_rd;
        idex_rw_d       = id_reg_write;
        idex_mr_d       = id_mem_read;

        exm_v_d  = idex_v_q;
        exm_rd_d = idex_rd_q;
        exm_rw_d = idex_rw_q;
        exm_mr_d = idex_mr_q;

        mwb_v_d  = exm_v_q;
        mwb_rd_d = exm_rd_q;
        mwb_rw_d = exm_rw_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_v_q        <= 1'b0;
            idex_rs1_q      <= '0;
            idex_rs2_q      <= '0;
            idex_rs1_used_q <= 1'b0;
            idex_rs2_used_q <= 1'b0;
            idex_rd_q       <= '0;
            idex_rw_q       <= 1'b0;
            idex_mr_q       <= 1'b0;
            exm_v_q         <= 1'b0;
            exm_rd_q        <= '0;
            exm_rw_q        <= 1'b0;
            exm_mr_q        <= 1'b0;
            mwb_v_q         <= 1'b0;
            mwb_rd_q        <= '0;
            mwb_rw_q        <= 1'b0;
        end else begin
            idex_v_q        <= idex_v_d;
            idex_rs1_q      <= idex_rs1_d;
            idex_rs2_q      <= idex_rs2_d;
            idex_rs1_used_q <= idex_rs1_used_d;
            idex_rs2_used_q <= idex_rs2_used_d;
            idex_rd_q       <= idex_rd_d;
            idex_rw_q       <= idex_rw_d;
            idex_mr_q       <= idex_mr_d;
            exm_v_q         <= exm_v_d;
            exm_rd_q        <= exm_rd_d;
            exm_rw_q        <= exm_rw_d;
            exm_mr_q        <= exm_mr_d;
            mwb_v_q         <= mwb_v_d;
            mwb_rd_q        <= mwb_rd_d;
            mwb_rw_q        <= mwb_rw_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_fwd_hazard_ctrl
//  Purpose  : Scoreboard bench for fwd_hazard_ctrl, directed pipeline
//             scenarios followed by randomized instruction streams.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_ctrl;

    localparam int RW = 5;

    typedef struct {
        bit          v;
        bit [RW-1:0] rs1, rs2;
        bit          u1, u2;
        bit [RW-1:0] rd;
        bit          rw, mr;
    } instr_t;

    typedef struct {
        bit [1:0] a, b;
        bit       st, bub;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, ex_flush;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall, idex_bubble;

    int checks = 0;
    int errors = 0;

    exp_t   sb_q[$];
    // pipe[0] = ID/EX, pipe[1] = EX/MEM, pipe[2] = MEM/WB
    instr_t pipe[3];

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.RW(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .idex_bubble  (idex_bubble)
    );

    function automatic void clear_pipe();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    endfunction

    // Newest older producer of src wins; x0 and non-writers never produce.
    function automatic bit [1:0] ref_fwd(input bit [RW-1:0] src, input bit used);
        if (!pipe[0].v || !used) return 2'b00;
        for (int s = 1; s <= 2; s++)
            if (pipe[s].v && pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == src)
                return 2'(s);
        return 2'b00;
    endfunction

    // Drive one cycle of ID inputs, predict outputs, then advance the model across the edge.
    task automatic step(input instr_t in, input bit flush, input bit rst);
        exp_t e;
        bit   hz;
        reset        = rst;
        id_valid     = in.v;
        id_rs1       = in.rs1;
        id_rs2       = in.rs2;
        id_rs1_used  = in.u1;
        id_rs2_used  = in.u2;
        id_rd        = in.rd;
        id_reg_write = in.rw;
        id_mem_read  = in.mr;
        ex_flush     = flush;
        hz = in.v && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
             ((in.u1 && in.rs1 == pipe[0].rd) || (in.u2 && in.rs2 == pipe[0].rd));
        e.a   = ref_fwd(pipe[0].rs1, pipe[0].u1);
        e.b   = ref_fwd(pipe[0].rs2, pipe[0].u2);
        e.st  = hz && !flush;
        e.bub = e.st || flush;
        sb_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            clear_pipe();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = in;
            pipe[0].v = in.v && !e.bub;
        end
        #1;
    endtask

    function automatic instr_t mk(input bit v, input int rd, input int rs1, input int rs2,
                                  input bit u1, input bit u2, input bit rw, input bit mr);
        instr_t t;
        t.v = v; t.rd = RW'(rd); t.rs1 = RW'(rs1); t.rs2 = RW'(rs2);
        t.u1 = u1; t.u2 = u2; t.rw = rw; t.mr = mr;
        return t;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t t;
        t.v   = ($urandom_range(0, 7) != 0);
        t.rs1 = RW'($urandom_range(0, 3));
        t.rs2 = RW'($urandom_range(0, 3));
        t.rd  = RW'($urandom_range(0, 3));
        t.u1  = ($urandom_range(0, 3) != 0);
        t.u2  = ($urandom_range(0, 1) != 0);
        t.mr  = ($urandom_range(0, 3) == 0);
        t.rw  = t.mr || ($urandom_range(0, 3) != 0);
        return t;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (fwd_a_sel !== e.a || fwd_b_sel !== e.b || stall !== e.st || idex_bubble !== e.bub) begin
                errors++;
                $display("FAIL outputs @%0t: got a=%b b=%b stall=%b bubble=%b, expected a=%b b=%b stall=%b bubble=%b",
                         $time, fwd_a_sel, fwd_b_sel, stall, idex_bubble, e.a, e.b, e.st, e.bub);
            end
        end
    end

    initial begin
        instr_t nop, t, lw, user;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        clear_pipe();
        reset = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_reg_write = 0; id_mem_read = 0; ex_flush = 0;
        @(posedge clk); #1;
        step(nop, 0, 1);

        // add x5 ; sub x6,x5,x1
        step(mk(1, 5, 1, 2, 1, 1, 1, 0), 0, 0);
        step(mk(1, 6, 5, 1, 1, 1, 1, 0), 0, 0);
        step(nop, 0, 0);
        // add x5 ; nop ; or x7,x2,x5
        step(mk(1, 5, 1, 2, 1, 1, 1, 0), 0, 0);
        step(nop, 0, 0);
        step(mk(1, 7, 2, 5, 1, 1, 1, 0), 0, 0);
        step(nop, 0, 0);
        // x5 written at both distances
        step(mk(1, 5, 1, 2, 1, 1, 1, 0), 0, 0);
        step(mk(1, 5, 3, 4, 1, 1, 1, 0), 0, 0);
        step(mk(1, 7, 2, 5, 1, 1, 1, 0), 0, 0);
        step(nop, 0, 0);
        // addi x0 ; add x3,x0,x0
        step(mk(1, 0, 1, 0, 1, 0, 1, 0), 0, 0);
        step(mk(1, 3, 0, 0, 1, 1, 1, 0), 0, 0);
        step(nop, 0, 0);
        // lw x7 ; add x8,x1,x7 (consumer re-presented after stall)
        lw   = mk(1, 7, 1, 0, 1, 0, 1, 1);
        user = mk(1, 8, 1, 7, 1, 1, 1, 0);
        step(lw, 0, 0);
        step(user, 0, 0);
        step(user, 0, 0);
        step(nop, 0, 0);
        step(nop, 0, 0);
        // lw x7 in EX with user in ID and flush
        step(lw, 0, 0);
        step(user, 1, 0);
        step(nop, 0, 0);
        step(nop, 0, 0);
        // reset in the middle of a dependent stream
        step(mk(1, 5, 1, 2, 1, 1, 1, 0), 0, 0);
        step(mk(1, 6, 5, 5, 1, 1, 1, 0), 0, 1);
        step(mk(1, 9, 5, 6, 1, 1, 1, 0), 0, 0);
        step(nop, 0, 0);

        t = nop;
        for (int i = 0; i < 600; i++) begin
            // Hold the instruction in ID while it is being stalled, as the core would.
            if (!(sb_q.size() == 0 && stall === 1'b1 && $urandom_range(0, 3) != 0))
                t = rnd_instr();
            step(t, ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0));
        end

        @(negedge clk); #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
